// File: rtl/stage3_a_beat_serializer.sv
// Serializes up to three captured 35-byte category-'a' messages into 64-bit keep/last beats.
// Optional msg_count output is enabled by defining STAGE3_A_MSG_CNT_EN.
module stage3_a_beat_serializer #(
    parameter int MSG_BYTES  = 35,
    parameter int BEAT_BYTES = 8,
    localparam int MSG_BITS  = 8 * MSG_BYTES,
    localparam int BEAT_BITS = 8 * BEAT_BYTES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_mask,
    input  logic [MSG_BITS-1:0]   message_a_1,
    input  logic [MSG_BITS-1:0]   message_a_2,
    input  logic [MSG_BITS-1:0]   message_a_3,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BEAT_BITS-1:0]  out_data,
    output logic [BEAT_BYTES-1:0] out_keep,
    output logic                  out_last,
`ifdef STAGE3_A_MSG_CNT_EN
    output logic [1:0]            out_lane,
    output logic [31:0]           msg_count
`else
    output logic [1:0]            out_lane
`endif
);

    localparam int NUM_BEATS  = (MSG_BYTES + BEAT_BYTES - 1) / BEAT_BYTES;
    localparam int TOT_BITS   = NUM_BEATS * BEAT_BITS;
    localparam int PAD_BITS   = TOT_BITS - MSG_BITS;
    localparam int LAST_BYTES = MSG_BYTES - (NUM_BEATS - 1) * BEAT_BYTES;
    localparam int BW         = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(NUM_BEATS - 1);
    localparam logic [BEAT_BYTES-1:0] LAST_KEEP = ~({BEAT_BYTES{1'b1}} >> LAST_BYTES);

    typedef enum logic {IDLE, SEND} state_e;

    // Message is left-aligned in a whole number of beats so the tail pads with zeros.
    function automatic logic [BEAT_BITS-1:0] beat_of(input logic [MSG_BITS-1:0] msg,
                                                     input logic [BW-1:0] k);
        logic [TOT_BITS-1:0] pad;
        pad = TOT_BITS'(msg) << PAD_BITS;
        pad = pad << (32'(k) * BEAT_BITS);
        return pad[TOT_BITS-1 -: BEAT_BITS];
    endfunction

    function automatic logic [1:0] low_lane(input logic [2:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else           return 2'd2;
    endfunction

    logic [2:0][MSG_BITS-1:0] in_msgs;
    assign in_msgs = {message_a_3, message_a_2, message_a_1};

    state_e                   state_q, state_d;
    logic                     in_ready_q, in_ready_d;
    logic [2:0][MSG_BITS-1:0] msg_q, msg_d;
    logic [2:0]               pend_q, pend_d;
    logic [1:0]               lane_q, lane_d;
    logic [BW-1:0]            beat_q, beat_d;
    logic                     out_valid_q, out_valid_d;
    logic [BEAT_BITS-1:0]     out_data_q, out_data_d;
    logic [BEAT_BYTES-1:0]    out_keep_q, out_keep_d;
    logic                     out_last_q, out_last_d;
    logic [1:0]               out_lane_q, out_lane_d;

    logic                     load;
    logic [MSG_BITS-1:0]      src;
    logic [1:0]               nlane;
    logic [BW-1:0]            nbeat;

    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        msg_d       = msg_q;
        pend_d      = pend_q;
        lane_d      = lane_q;
        beat_d      = beat_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        out_lane_d  = out_lane_q;
        load        = 1'b0;
        src         = msg_q[lane_q];
        nlane       = lane_q;
        nbeat       = beat_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    msg_d = in_msgs;
                    if (in_mask != 3'b000) begin
                        nlane      = low_lane(in_mask);
                        nbeat      = '0;
                        src        = in_msgs[nlane];
                        pend_d     = in_mask & ~(3'b001 << nlane);
                        state_d    = SEND;
                        in_ready_d = 1'b0;
                        load       = 1'b1;
                    end
                end
            end
            SEND: begin
                if (out_valid_q && out_ready) begin
                    if (beat_q != LAST_BEAT) begin
                        nbeat = beat_q + BW'(1);
                        load  = 1'b1;
                    end else if (pend_q != 3'b000) begin
                        nlane  = low_lane(pend_q);
                        nbeat  = '0;
                        src    = msg_q[nlane];
                        pend_d = pend_q & ~(3'b001 << nlane);
                        load   = 1'b1;
                    end else begin
                        state_d     = IDLE;
                        in_ready_d  = 1'b1;
                        out_valid_d = 1'b0;
                        out_data_d  = '0;
                        out_keep_d  = '0;
                        out_last_d  = 1'b0;
                        out_lane_d  = 2'd0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Capture and advance share one beat loader so all outputs stay registered.
        if (load) begin
            lane_d      = nlane;
            beat_d      = nbeat;
            out_valid_d = 1'b1;
            out_data_d  = beat_of(src, nbeat);
            out_keep_d  = (nbeat == LAST_BEAT) ? LAST_KEEP : '1;
            out_last_d  = (nbeat == LAST_BEAT);
            out_lane_d  = nlane + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            msg_q       <= '0;
            pend_q      <= '0;
            lane_q      <= '0;
            beat_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
            out_lane_q  <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            msg_q       <= msg_d;
            pend_q      <= pend_d;
            lane_q      <= lane_d;
            beat_q      <= beat_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
            out_lane_q  <= out_lane_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_keep  = out_keep_q;
    assign out_last  = out_last_q;
    assign out_lane  = out_lane_q;

`ifdef STAGE3_A_MSG_CNT_EN
    logic [31:0] msg_count_q, msg_count_d;

    always_comb begin
        msg_count_d = msg_count_q;
        if (out_valid_q && out_ready && out_last_q) msg_count_d = msg_count_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) msg_count_q <= '0;
        else        msg_count_q <= msg_count_d;
    end

    assign msg_count = msg_count_q;
`endif

endmodule

// File: tb/tb_stage3_a_beat_serializer.sv
module tb_stage3_a_beat_serializer;
  localparam int MB = 35;
  localparam int NB = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   in_mask = 3'b000;
  logic [279:0] m1 = '0, m2 = '0, m3 = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [63:0]  out_data;
  logic [7:0]   out_keep;
  logic         out_last;
  logic [1:0]   out_lane;
`ifdef STAGE3_A_MSG_CNT_EN
  logic [31:0]  msg_count;
  logic [31:0]  mc_exp = '0;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic [1:0]  ln;
  } beat_t;

  logic [279:0] gm [1:3];
  beat_t        exp_q[$];

  stage3_a_beat_serializer dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mask(in_mask),
    .message_a_1(m1), .message_a_2(m2), .message_a_3(m3),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_keep(out_keep), .out_last(out_last),
`ifdef STAGE3_A_MSG_CNT_EN
    .out_lane(out_lane), .msg_count(msg_count)
`else
    .out_lane(out_lane)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t model_beat(input int n, input int k);
    beat_t b;
    int idx;
    b = '0;
    for (int j = 0; j < 8; j++) begin
      idx = k * 8 + j;
      if (idx < MB) begin
        b.d[63 - 8*j -: 8] = gm[n][(MB - 1 - idx) * 8 +: 8];
        b.k[7 - j] = 1'b1;
      end
    end
    b.l  = (k == NB - 1);
    b.ln = 2'(n);
    return b;
  endfunction

  task automatic fill_msgs(input bit pattern);
    logic [7:0] by;
    for (int n = 1; n <= 3; n++)
      for (int i = 0; i < MB; i++) begin
        by = pattern ? {n[3:0], i[3:0]} : 8'($urandom);
        gm[n][(MB - 1 - i) * 8 +: 8] = by;
      end
  endtask

  task automatic run_group(input logic [2:0] mask, input int mode);
    int    hold = 0;
    int    got = 0;
    bit    have_prev = 0;
    bit    rdy;
    beat_t prev, cur, e;
    chk("idle_in_ready", in_ready, 1'b1);
    chk("idle_out_valid", out_valid, 1'b0);
    m1 = gm[1]; m2 = gm[2]; m3 = gm[3];
    in_mask  = mask;
    in_valid = 1'b1;
    exp_q.delete();
    for (int n = 1; n <= 3; n++)
      if (mask[n-1])
        for (int k = 0; k < NB; k++) exp_q.push_back(model_beat(n, k));
    @(negedge clk);
    in_valid = 1'b0;
    m1 = ~gm[1]; m2 = ~gm[2]; m3 = ~gm[3];
    in_mask = ~mask;
    if (mask == 3'b000) begin
      chk("drop_out_valid", out_valid, 1'b0);
      chk("drop_in_ready", in_ready, 1'b1);
      return;
    end
    chk("busy_in_ready", in_ready, 1'b0);
    for (int cyc = 0; cyc < 400 && exp_q.size() > 0; cyc++) begin
      cur = {out_data, out_keep, out_last, out_lane};
      chk("valid_held", out_valid, 1'b1);
      if (have_prev) chk("stall_stable", cur, prev);
      if (mode == 2 && got == 1 && hold < 4) begin
        rdy = 1'b0;
        hold++;
      end else if (mode != 0) rdy = 1'($urandom_range(0, 1));
      else rdy = 1'b1;
      out_ready = rdy;
      if (rdy) begin
        e = exp_q.pop_front();
        chk("beat_data", out_data, e.d);
        chk("beat_keep", out_keep, e.k);
        chk("beat_last", out_last, e.l);
        chk("beat_lane", out_lane, e.ln);
`ifdef STAGE3_A_MSG_CNT_EN
        if (e.l) mc_exp = mc_exp + 32'd1;
`endif
        have_prev = 1'b0;
        got++;
      end else begin
        prev = cur;
        have_prev = 1'b1;
      end
      @(negedge clk);
    end
    chk("all_beats_seen", exp_q.size(), 0);
    chk("done_out_valid", out_valid, 1'b0);
    chk("done_in_ready", in_ready, 1'b1);
    out_ready = 1'b0;
`ifdef STAGE3_A_MSG_CNT_EN
    chk("msg_count", msg_count, mc_exp);
`endif
  endtask

  initial begin
    int n;
    bit found;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 64'h0);
    chk("rst_out_keep", out_keep, 8'h00);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_out_lane", out_lane, 2'd0);
    rst_n = 1'b1;
    @(negedge clk);

    fill_msgs(1'b1);
    run_group(3'b111, 0);

    fill_msgs(1'b0);
    run_group(3'b101, 0);

    run_group(3'b000, 0);
    fill_msgs(1'b0);
    run_group(3'b110, 0);

    fill_msgs(1'b0);
    run_group(3'b010, 2);
    fill_msgs(1'b0);
    run_group(3'b111, 1);

    fill_msgs(1'b0);
    m1 = gm[1]; m2 = gm[2]; m3 = gm[3];
    in_mask = 3'b111;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (out_valid && n == 7) begin
        found = 1'b1;
        break;
      end
      if (out_valid) n++;
      @(negedge clk);
    end
    chk("abort_wait_expired", found, 1'b1);
    chk("abort_point_lane", out_lane, 2'd2);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_in_ready", in_ready, 1'b1);
    @(negedge clk);
    chk("abort_hold_valid", out_valid, 1'b0);
    chk("abort_out_keep", out_keep, 8'h00);
    chk("abort_out_lane", out_lane, 2'd0);
`ifdef STAGE3_A_MSG_CNT_EN
    mc_exp = '0;
    chk("abort_msg_count", msg_count, mc_exp);
`endif
    rst_n = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("post_abort_valid", out_valid, 1'b0);
    fill_msgs(1'b0);
    run_group(3'b001, 0);

`ifdef STAGE3_A_MSG_CNT_EN
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mc_exp = '0;
    @(negedge clk);
    fill_msgs(1'b1);
    run_group(3'b111, 0);
    run_group(3'b111, 0);
    chk("count_six", msg_count, 32'd6);
    force dut.msg_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.msg_count_q;
    mc_exp = 32'hFFFF_FFFF;
    @(negedge clk);
    run_group(3'b100, 0);
    chk("count_wrap", msg_count, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
